// File: rtl/alarm_clock_core.sv
// -----------------------------------------------------------------------------
// alarm_clock_core
//
// Timekeeping and alarm controller. Keeps a 24 h HH:MM:SS clock and
// NUM_ALARMS HH:MM alarm registers. An edit-mode FSM runs from one-cycle
// debounced button pulses. A ring output is raised on an alarm match and
// stops automatically after RING_SEC seconds. The block drives BCD digits
// to the display path.
//
// Optional feature macro: ALARM_SNOOZE_EN
//   When defined, up/down during a ring start a SNOOZE_MIN minute snooze.
//   The ring restarts when the snooze ends. center cancels a pending snooze.
//   When undefined, no snooze counter is built.
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   tick_1hz   one-cycle pulse per second, synchronous to clk
//   up/down/right/left/center  one-cycle debounced button pulses
//   alarm_sw   per-alarm arm switches (bit k arms alarm k)
//   th1, th2   displayed hours tens / units (BCD)
//   tm1, tm2   displayed minutes tens / units (BCD)
//   mode       FSM state: CLK=0, SET_TH=1, SET_TM=2, SET_AH=3, SET_AM=4
//   alarm_idx  alarm currently being edited
//   blink      field under edit: bit1 hours, bit0 minutes
//   ring       alarm sounding
//   ring_idx   alarm that caused the current ring
// -----------------------------------------------------------------------------
module alarm_clock_core #(
    parameter  int NUM_ALARMS = 2,
    parameter  int RING_SEC   = 60,
    parameter  int SNOOZE_MIN = 5,
    localparam int IW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tick_1hz,
    input  logic                  up,
    input  logic                  down,
    input  logic                  right,
    input  logic                  left,
    input  logic                  center,
    input  logic [NUM_ALARMS-1:0] alarm_sw,
    output logic [1:0]            th1,
    output logic [3:0]            th2,
    output logic [2:0]            tm1,
    output logic [3:0]            tm2,
    output logic [2:0]            mode,
    output logic [IW-1:0]         alarm_idx,
    output logic [1:0]            blink,
    output logic                  ring,
    output logic [IW-1:0]         ring_idx
);

    // Elaboration-time parameter range checks.
    if (NUM_ALARMS < 1 || NUM_ALARMS > 8) begin : g_bad_num_alarms
        $error("alarm_clock_core: NUM_ALARMS must be 1..8");
    end
    if (RING_SEC < 1 || RING_SEC > 255) begin : g_bad_ring_sec
        $error("alarm_clock_core: RING_SEC must be 1..255");
    end
    if (SNOOZE_MIN < 1) begin : g_bad_snooze_min
        $error("alarm_clock_core: SNOOZE_MIN must be at least 1");
    end

    typedef enum logic [2:0] {
        MODE_CLK    = 3'd0,
        MODE_SET_TH = 3'd1,
        MODE_SET_TM = 3'd2,
        MODE_SET_AH = 3'd3,
        MODE_SET_AM = 3'd4
    } mode_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_ALARMS - 1);

`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
`endif

    // ------------------------------------------------------------------
    // State registers and their next-state values
    // ------------------------------------------------------------------
    mode_t          mode_q, mode_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [5:0]     sec_q, sec_d;
    logic [5:0]     min_q, min_d;
    logic [4:0]     hr_q, hr_d;
    logic [4:0]     ahr_q  [NUM_ALARMS];
    logic [4:0]     ahr_d  [NUM_ALARMS];
    logic [5:0]     amin_q [NUM_ALARMS];
    logic [5:0]     amin_d [NUM_ALARMS];
    logic           ring_q, ring_d;
    logic [IW-1:0]  ring_idx_q, ring_idx_d;
    logic [7:0]     ring_cnt_q, ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
    logic [SNZ_W-1:0] snz_cnt_q, snz_cnt_d;
`endif

    // ------------------------------------------------------------------
    // Helpers: wrap-around step for hour and minute fields
    // ------------------------------------------------------------------
    function automatic logic [4:0] hr_step(input logic [4:0] v,
                                           input logic inc, input logic dec);
        hr_step = v;
        if (inc)      hr_step = (v == 5'd23) ? 5'd0  : v + 5'd1;
        else if (dec) hr_step = (v == 5'd0)  ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] min_step(input logic [5:0] v,
                                            input logic inc, input logic dec);
        min_step = v;
        if (inc)      min_step = (v == 6'd59) ? 6'd0  : v + 6'd1;
        else if (dec) min_step = (v == 6'd0)  ? 6'd59 : v - 6'd1;
    endfunction

    // ------------------------------------------------------------------
    // Time after one second has elapsed (used both for advancing and
    // for alarm matching, which looks at the post-increment time).
    // ------------------------------------------------------------------
    logic [5:0] sec_inc, min_inc;
    logic [4:0] hr_inc;

    // NOTE: every signal written in an always_comb gets a default first,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        sec_inc = sec_q + 6'd1;
        min_inc = min_q;
        hr_inc  = hr_q;
        if (sec_q == 6'd59) begin
            sec_inc = 6'd0;
            if (min_q == 6'd59) begin
                min_inc = 6'd0;
                hr_inc  = (hr_q == 5'd23) ? 5'd0 : hr_q + 5'd1;
            end else begin
                min_inc = min_q + 6'd1;
            end
        end
    end

    logic advance;
    assign advance = tick_1hz && (mode_q == MODE_CLK    ||
                                  mode_q == MODE_SET_AH ||
                                  mode_q == MODE_SET_AM);

    // Armed alarms equal to the post-increment HH:MM; lowest index wins.
    logic [NUM_ALARMS-1:0] hit;
    logic [IW-1:0]         match_idx;
    logic                  match_now;

    always_comb begin
        hit       = '0;
        match_idx = '0;
        for (int k = 0; k < NUM_ALARMS; k++) begin
            hit[k] = alarm_sw[k] && (ahr_q[k] == hr_inc) && (amin_q[k] == min_inc);
        end
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (hit[k]) match_idx = IW'(k);
        end
    end

    assign match_now = advance && (sec_inc == 6'd0) && (|hit);

    // ------------------------------------------------------------------
    // Button qualification. While ringing, center only dismisses; with
    // snooze built in, up/down only snooze and center cancels a snooze.
    // ------------------------------------------------------------------
    logic center_taken;
    logic adjust_taken;
    logic nav_center;
    logic inc, dec;

    always_comb begin
`ifdef ALARM_SNOOZE_EN
        center_taken = ring_q || (snz_cnt_q != '0);
        adjust_taken = ring_q;
`else
        center_taken = ring_q;
        adjust_taken = 1'b0;
`endif
        nav_center = center && !center_taken;
        inc        = up && !down && !adjust_taken;
        dec        = down && !up && !adjust_taken;
    end

    // ------------------------------------------------------------------
    // Next-state logic: FSM, time, alarms, ring, snooze
    // ------------------------------------------------------------------
    always_comb begin
        mode_d     = mode_q;
        idx_d      = idx_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        ahr_d      = ahr_q;
        amin_d     = amin_q;
        ring_d     = ring_q;
        ring_idx_d = ring_idx_q;
        ring_cnt_d = ring_cnt_q;
`ifdef ALARM_SNOOZE_EN
        snz_cnt_d  = snz_cnt_q;
`endif

        // Timekeeping: adjust and advance never apply in the same mode.
        if (advance) begin
            sec_d = sec_inc;
            min_d = min_inc;
            hr_d  = hr_inc;
        end

        unique case (mode_q)
            MODE_SET_TH: hr_d          = hr_step(hr_q, inc, dec);
            MODE_SET_TM: min_d         = min_step(min_q, inc, dec);
            MODE_SET_AH: ahr_d[idx_q]  = hr_step(ahr_q[idx_q], inc, dec);
            MODE_SET_AM: amin_d[idx_q] = min_step(amin_q[idx_q], inc, dec);
            default: ;
        endcase

        // Navigation: center beats right, right beats left.
        if (nav_center) begin
            mode_d = (mode_q == MODE_CLK) ? MODE_SET_TH : MODE_CLK;
        end else if (right) begin
            unique case (mode_q)
                MODE_CLK:    mode_d = MODE_CLK;
                MODE_SET_TH: mode_d = MODE_SET_TM;
                MODE_SET_TM: begin
                    mode_d = MODE_SET_AH;
                    idx_d  = '0;
                end
                MODE_SET_AH: mode_d = MODE_SET_AM;
                MODE_SET_AM: begin
                    if (idx_q == LAST_IDX) begin
                        mode_d = MODE_SET_TH;
                    end else begin
                        mode_d = MODE_SET_AH;
                        idx_d  = idx_q + IW'(1);
                    end
                end
                default: mode_d = MODE_CLK;
            endcase
        end else if (left) begin
            unique case (mode_q)
                MODE_CLK:    mode_d = MODE_CLK;
                MODE_SET_TH: begin
                    mode_d = MODE_SET_AM;
                    idx_d  = LAST_IDX;
                end
                MODE_SET_TM: mode_d = MODE_SET_TH;
                MODE_SET_AH: begin
                    if (idx_q == '0) begin
                        mode_d = MODE_SET_TM;
                    end else begin
                        mode_d = MODE_SET_AM;
                        idx_d  = idx_q - IW'(1);
                    end
                end
                MODE_SET_AM: mode_d = MODE_SET_AH;
                default:     mode_d = MODE_CLK;
            endcase
        end

        // Seconds restart from zero whenever the hour edit is entered.
        if (mode_d == MODE_SET_TH && mode_q != MODE_SET_TH) begin
            sec_d = 6'd0;
        end

        // Ring and snooze control.
        if (ring_q) begin
            if (tick_1hz) begin
                ring_cnt_d = ring_cnt_q - 8'd1;
                if (ring_cnt_q == 8'd1) ring_d = 1'b0;
            end
            if (center) begin
                ring_d     = 1'b0;
                ring_cnt_d = 8'd0;
            end
`ifdef ALARM_SNOOZE_EN
            if (up || down) begin
                ring_d     = 1'b0;
                ring_cnt_d = 8'd0;
                snz_cnt_d  = SNZ_W'(SNZ_TICKS);
            end
`endif
        end else begin
`ifdef ALARM_SNOOZE_EN
            if (snz_cnt_q != '0) begin
                if (center) begin
                    snz_cnt_d = '0;
                end else if (tick_1hz) begin
                    snz_cnt_d = snz_cnt_q - SNZ_W'(1);
                    if (snz_cnt_q == SNZ_W'(1)) begin
                        ring_d     = 1'b1;
                        ring_cnt_d = 8'(RING_SEC);
                    end
                end
            end
`endif
            // A fresh match overrides a pending or expiring snooze.
            if (match_now) begin
                ring_d     = 1'b1;
                ring_idx_d = match_idx;
                ring_cnt_d = 8'(RING_SEC);
`ifdef ALARM_SNOOZE_EN
                snz_cnt_d  = '0;
`endif
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= MODE_CLK;
            idx_q      <= '0;
            sec_q      <= 6'd0;
            min_q      <= 6'd0;
            hr_q       <= 5'd0;
            ring_q     <= 1'b0;
            ring_idx_q <= '0;
            ring_cnt_q <= 8'd0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
            // NOTE: the alarm bank is a handful of flops rather than a RAM,
            // and a known 00:00 after reset is visible behaviour, so it is reset.
            for (int k = 0; k < NUM_ALARMS; k++) begin
                ahr_q[k]  <= 5'd0;
                amin_q[k] <= 6'd0;
            end
        end else begin
            mode_q     <= mode_d;
            idx_q      <= idx_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            ring_q     <= ring_d;
            ring_idx_q <= ring_idx_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= snz_cnt_d;
`endif
            for (int k = 0; k < NUM_ALARMS; k++) begin
                ahr_q[k]  <= ahr_d[k];
                amin_q[k] <= amin_d[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    logic       show_alarm;
    logic [4:0] disp_hr;
    logic [5:0] disp_min;

    assign show_alarm = (mode_q == MODE_SET_AH) || (mode_q == MODE_SET_AM);
    assign disp_hr    = show_alarm ? ahr_q[idx_q]  : hr_q;
    assign disp_min   = show_alarm ? amin_q[idx_q] : min_q;

    // Binary to BCD for values bounded by 23 and 59.
    always_comb begin
        th1 = 2'd0;
        if (disp_hr >= 5'd20)      th1 = 2'd2;
        else if (disp_hr >= 5'd10) th1 = 2'd1;
        th2 = 4'(disp_hr - 5'(th1) * 5'd10);

        tm1 = 3'd0;
        if (disp_min >= 6'd50)      tm1 = 3'd5;
        else if (disp_min >= 6'd40) tm1 = 3'd4;
        else if (disp_min >= 6'd30) tm1 = 3'd3;
        else if (disp_min >= 6'd20) tm1 = 3'd2;
        else if (disp_min >= 6'd10) tm1 = 3'd1;
        tm2 = 4'(disp_min - 6'(tm1) * 6'd10);
    end

    always_comb begin
        blink = 2'b00;
        unique case (mode_q)
            MODE_SET_TH, MODE_SET_AH: blink = 2'b10;
            MODE_SET_TM, MODE_SET_AM: blink = 2'b01;
            default:                  blink = 2'b00;
        endcase
    end

    assign mode      = mode_q;
    assign alarm_idx = idx_q;
    assign ring      = ring_q;
    assign ring_idx  = ring_idx_q;

endmodule
